bht_btb_predictor: RTL

- Dynamic branch predictor for the 5-stage RISC-V pipeline: direct-mapped branch history table (BHT) of saturating counters, plus a tagged branch target buffer (BTB).
- Queried combinationally by IF with the fetch PC.
- Trained at the clock edge by EX with the resolved branch outcome.
- Reports mispredicts to the PCSrc/flush logic and keeps branch and mispredict statistics.
- Replaces static predict-not-taken; depth and counter width are parametrised.

---
 rtl/bht_btb_predictor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bht_btb_predictor.sv
// Dynamic branch predictor: direct-mapped BHT of saturating counters plus tagged BTB.
// Lookup is combinational on the fetch PC; training happens at the clock edge from EX.
module bht_btb_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_all,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
        return (c == '0) ? c : c - CNT_BITS'(1);
    endfunction

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [CNT_BITS-1:0]   r_cnt    [ENTRIES];
    logic [STAT_WIDTH-1:0] r_branch_cnt;
    logic [STAT_WIDTH-1:0] r_mispred_cnt;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_W-1:0]      w_if_tag;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd_hit;
    logic                  w_wr_en;
    logic                  w_alloc;
    logic                  w_train;
    logic                  w_unused_lsbs;

    assign w_if_idx  = pc_if[INDEX_BITS+1:2];
    assign w_if_tag  = pc_if[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    // Instruction-alignment bits never participate in indexing or tagging.
    assign w_unused_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

    assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = pred_hit && r_cnt[w_if_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : pc_if + ADDR_WIDTH'(4);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_wr_en   = upd_valid && !flush_all;
    assign w_alloc   = w_wr_en && !w_upd_hit && upd_taken;
    assign w_train   = w_wr_en && w_upd_hit;

    // Flush wins over a concurrent allocation; counters are left alone by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (flush_all) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_WNT;
            end
        end else if (w_alloc) begin
            r_cnt[w_upd_idx] <= CNT_WT;
        end else if (w_train) begin
            r_cnt[w_upd_idx] <= upd_taken ? sat_inc(r_cnt[w_upd_idx])
                                          : sat_dec(r_cnt[w_upd_idx]);
        end
    end

    // Tag and target storage is only meaningful behind a valid bit, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end else if (w_train && upd_taken) begin
            r_target[w_upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_branch_cnt  <= r_branch_cnt + STAT_WIDTH'(upd_valid);
            r_mispred_cnt <= r_mispred_cnt + STAT_WIDTH'(mispredict);
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
